// File: rtl/spi_slave_pkg.sv
// spi_slave_pkg: shared modes, FSM state and defaults
// for the PCLK-domain SPI slave.
package spi_slave_pkg;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

endpackage

// File: rtl/spi_sync.sv
// spi_sync: STAGES-deep single-bit synchronizer
// with a parameterised reset value.
module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // shift the pin level through the flop chain
  always_ff @(posedge clk) begin
    if (!rst_n) ff <= {STAGES{RST_VAL}};
    else        ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/spi_slave_sync.sv
// spi_slave_sync: fully PCLK-synchronous SPI slave, 4 modes.
// Optional SPI_SLAVE_LSB_FIRST_EN adds the LSB_FIRST input.
module spi_slave_sync
  import spi_slave_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic             SCK,
  input  logic             SS,
  input  logic             MOSI,
  output logic             MISO,
  output logic             MISO_OE,
  input  logic [1:0]       MODE,
`ifdef SPI_SLAVE_LSB_FIRST_EN
  input  logic             LSB_FIRST,
`endif
  input  logic [WIDTH-1:0] TX_DATA,
  input  logic             TX_VALID,
  output logic             TX_READY,
  output logic [WIDTH-1:0] RX_DATA,
  output logic             RX_VALID,
  input  logic             RX_READY,
  output logic             BUSY,
  output logic             OVERRUN,
  output logic             UNDERRUN
);

  localparam int CW = $clog2(WIDTH);

  logic sck_s, ss_s, mosi_s, sck_d;
  state_t state_q, state_d;
  logic start, stop;
  logic cpol_q, cpha_q, lsb_q, lsb_in;
  logic hold_q, bit_q;
  logic [CW-1:0] cnt_q;
  logic [WIDTH-1:0] sh_q, tx_buf_q, rx_data_q;
  logic tx_full_q, rx_valid_q;
  logic miso_q, ovr_q, und_q;
  logic rise, fall, lead, trail;
  logic sample_e, shift_e, last, run;
  logic word_done, consume, tx_load;
  logic [WIDTH-1:0] reload, shifted, word;

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0))
    u_sck (.clk(PCLK), .rst_n(PRESETn),
           .d(SCK), .q(sck_s));
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1))
    u_ss (.clk(PCLK), .rst_n(PRESETn),
          .d(SS), .q(ss_s));
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0))
    u_mosi (.clk(PCLK), .rst_n(PRESETn),
            .d(MOSI), .q(mosi_s));

`ifdef SPI_SLAVE_LSB_FIRST_EN
  assign lsb_in = LSB_FIRST;
`else
  assign lsb_in = 1'b0;
`endif

  assign rise  = sck_s & ~sck_d;
  assign fall  = ~sck_s & sck_d;
  assign lead  = cpol_q ? fall : rise;
  assign trail = cpol_q ? rise : fall;

  assign sample_e = cpha_q ? trail : lead;
  assign shift_e  = cpha_q ? lead : trail;

  assign last = (cnt_q == CW'(WIDTH-1));
  assign run  = (state_q == ACTIVE) && !ss_s;

  assign word_done = run & sample_e & last;
  assign consume   = start | word_done;
  assign tx_load   = TX_VALID & ~tx_full_q;

  assign reload  = tx_full_q ? tx_buf_q : '0;
  assign shifted = lsb_q ? {bit_q, sh_q[WIDTH-1:1]}
                         : {sh_q[WIDTH-2:0], bit_q};
  assign word    = lsb_q ? {mosi_s, sh_q[WIDTH-1:1]}
                         : {sh_q[WIDTH-2:0], mosi_s};

  // delayed SCK copy for edge detection
  always_ff @(posedge PCLK) begin
    if (!PRESETn) sck_d <= 1'b0;
    else          sck_d <= sck_s;
  end

  // next state from synchronized SS
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    stop    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!ss_s) begin
          state_d = ACTIVE;
          start   = 1'b1;
        end
      end
      ACTIVE: begin
        if (ss_s) begin
          state_d = IDLE;
          stop    = 1'b1;
        end
      end
    endcase
  end

  // state, mode latch, bit counter and shift register
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      lsb_q   <= 1'b0;
      hold_q  <= 1'b0;
      bit_q   <= 1'b0;
      cnt_q   <= '0;
      sh_q    <= '0;
      miso_q  <= 1'b0;
      und_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      und_q   <= 1'b0;
      miso_q  <= lsb_q ? sh_q[0] : sh_q[WIDTH-1];
      if (start) begin
        cpol_q <= MODE[1];
        cpha_q <= MODE[0];
        lsb_q  <= lsb_in;
        hold_q <= MODE[0];
        cnt_q  <= '0;
        sh_q   <= reload;
        und_q  <= ~tx_full_q;
      end else if (stop) begin
        cnt_q <= '0;
      end else if (run && sample_e) begin
        bit_q <= mosi_s;
        if (last) begin
          // the pending shift edge of this word
          // must not disturb the freshly loaded word
          cnt_q  <= '0;
          sh_q   <= reload;
          hold_q <= 1'b1;
          und_q  <= ~tx_full_q;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end else if (run && shift_e) begin
        if (hold_q) hold_q <= 1'b0;
        else        sh_q   <= shifted;
      end
    end
  end

  // TX holding buffer and RX output register
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      tx_full_q  <= 1'b0;
      tx_buf_q   <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      ovr_q     <= 1'b0;
      tx_full_q <= (tx_full_q & ~consume) | tx_load;
      if (tx_load) tx_buf_q <= TX_DATA;
      if (word_done) begin
        if (rx_valid_q && !RX_READY) begin
          ovr_q <= 1'b1;
        end else begin
          rx_data_q  <= word;
          rx_valid_q <= 1'b1;
        end
      end else if (rx_valid_q && RX_READY) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  assign MISO     = miso_q;
  assign MISO_OE  = ~ss_s;
  assign BUSY     = ~ss_s;
  assign TX_READY = ~tx_full_q;
  assign RX_DATA  = rx_data_q;
  assign RX_VALID = rx_valid_q;
  assign OVERRUN  = ovr_q;
  assign UNDERRUN = und_q;

endmodule

// File: tb/tb_spi_slave_sync.sv
// tb_spi_slave_sync: directed SPI master stimulus with
// a per-cycle monitor for the 8-bit slave.
module tb_spi_slave_sync;
  import spi_slave_pkg::*;

  localparam int S = 2;
  localparam int H = 6;

  logic pclk = 1'b0;
  logic rst_n = 1'b0;
  logic sck = 1'b0;
  logic mosi = 1'b0;
  logic ss8 = 1'b1;
  logic ss16 = 1'b1;
  logic [1:0] mode = MODE0;

  logic miso8, oe8, busy8, ovr8, und8;
  logic txr8, rxv8;
  logic rx_ready = 1'b1;
  logic txv8 = 1'b0;
  logic [7:0] txd8 = '0;
  logic [7:0] rxd8;

  logic miso16, oe16, busy16, ovr16, und16;
  logic txr16, rxv16;
  logic rx16_ready = 1'b0;
  logic txv16 = 1'b0;
  logic [15:0] txd16 = '0;
  logic [15:0] rxd16;

`ifdef SPI_SLAVE_LSB_FIRST_EN
  logic lsb_first = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int ovr_cnt = 0;
  int und_cnt = 0;

  logic [7:0] exp_rx[$];
  logic [7:0] held = '0;
  logic [7:0] dl = '1;
  logic rst_smp = 1'b0;
  logic ss_smp = 1'b1;
  logic pv = 1'b0;
  logic pr = 1'b0;
  logic po = 1'b0;
  logic pu = 1'b0;

  logic [31:0] mi;
  logic [31:0] junk;

  spi_slave_sync #(.WIDTH(8), .SYNC_STAGES(S)) u8 (
    .PCLK(pclk), .PRESETn(rst_n),
    .SCK(sck), .SS(ss8), .MOSI(mosi),
    .MISO(miso8), .MISO_OE(oe8), .MODE(mode),
`ifdef SPI_SLAVE_LSB_FIRST_EN
    .LSB_FIRST(lsb_first),
`endif
    .TX_DATA(txd8), .TX_VALID(txv8), .TX_READY(txr8),
    .RX_DATA(rxd8), .RX_VALID(rxv8), .RX_READY(rx_ready),
    .BUSY(busy8), .OVERRUN(ovr8), .UNDERRUN(und8)
  );

  spi_slave_sync #(.WIDTH(16), .SYNC_STAGES(S)) u16 (
    .PCLK(pclk), .PRESETn(rst_n),
    .SCK(sck), .SS(ss16), .MOSI(mosi),
    .MISO(miso16), .MISO_OE(oe16), .MODE(mode),
`ifdef SPI_SLAVE_LSB_FIRST_EN
    .LSB_FIRST(1'b0),
`endif
    .TX_DATA(txd16), .TX_VALID(txv16), .TX_READY(txr16),
    .RX_DATA(rxd16), .RX_VALID(rxv16), .RX_READY(rx16_ready),
    .BUSY(busy16), .OVERRUN(ovr16), .UNDERRUN(und16)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  // write one word into the selected TX buffer
  task automatic txw(input bit w16, input logic [15:0] d);
    int k = 0;
    if (w16) begin
      txd16 = d;
      txv16 = 1'b1;
    end else begin
      txd8 = d[7:0];
      txv8 = 1'b1;
    end
    while (!(w16 ? txr16 : txr8) && k < 100) begin
      cyc(1);
      k++;
    end
    chk("tx_accept", {31'd0, (w16 ? txr16 : txr8)}, 1);
    cyc(1);
    txv8 = 1'b0;
    txv16 = 1'b0;
  endtask

  // SPI master: n bits of mo, first bit = mo[n-1]
  task automatic xfer(input bit w16,
                      input logic [1:0] m,
                      input logic [31:0] mo,
                      input int n,
                      output logic [31:0] got);
    logic cp;
    logic [31:0] r = '0;
    cp = m[0];
    mode = m;
    sck = m[1];
    cyc(8);
    if (w16) ss16 = 1'b0;
    else     ss8 = 1'b0;
    if (!cp) mosi = mo[n-1];
    cyc(8);
    for (int i = 0; i < n; i++) begin
      if (!cp) begin
        r[n-1-i] = w16 ? miso16 : miso8;
        sck = ~sck;
        cyc(H);
        sck = ~sck;
        if (i < n - 1) mosi = mo[n-2-i];
        cyc(H);
      end else begin
        sck = ~sck;
        mosi = mo[n-1-i];
        cyc(H);
        r[n-1-i] = w16 ? miso16 : miso8;
        sck = ~sck;
        cyc(H);
      end
    end
    cyc(2);
    ss8 = 1'b1;
    ss16 = 1'b1;
    cyc(8);
    got = r;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_miso"}, {31'd0, miso8}, 0);
    chk({tag, "_oe"}, {31'd0, oe8}, 0);
    chk({tag, "_rxd"}, {24'd0, rxd8}, 0);
    chk({tag, "_rxv"}, {31'd0, rxv8}, 0);
    chk({tag, "_txr"}, {31'd0, txr8}, 1);
    chk({tag, "_busy"}, {31'd0, busy8}, 0);
    chk({tag, "_ovr"}, {31'd0, ovr8}, 0);
    chk({tag, "_und"}, {31'd0, und8}, 0);
  endtask

  // per-cycle monitor of the 8-bit slave
  always @(negedge pclk) begin
    if (!rst_smp) dl = '1;
    else          dl = {dl[6:0], ss_smp};
    chk("busy", {31'd0, busy8}, {31'd0, ~dl[S-1]});
    chk("miso_oe", {31'd0, oe8}, {31'd0, ~dl[S-1]});
    if (rst_n) begin
      if (rxv8 && !pv) begin
        chk("rx_expected", {31'd0, exp_rx.size() > 0}, 1);
        if (exp_rx.size() > 0) begin
          held = exp_rx.pop_front();
          chk("rx_data", {24'd0, rxd8}, {24'd0, held});
        end
      end else if (rxv8 && pv && !pr) begin
        chk("rx_hold", {24'd0, rxd8}, {24'd0, held});
      end
      if (ovr8) ovr_cnt++;
      if (und8) und_cnt++;
      chk("pulse_width", {30'd0, ovr8 & po, und8 & pu}, 0);
    end
    rst_smp = rst_n;
    ss_smp = ss8;
    pv = rxv8;
    pr = rx_ready;
    po = ovr8;
    pu = und8;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(3);
    check_reset("rst0");
    rst_n = 1'b1;
    cyc(4);

    // mode 0 single word
    rx_ready = 1'b1;
    txw(0, 16'h00A5);
    chk("t1_txfull", {31'd0, txr8}, 0);
    exp_rx.push_back(8'h3C);
    und_cnt = 0;
    xfer(0, MODE0, 32'h3C, 8, mi);
    chk("t1_miso", mi, 32'hA5);
    chk("t1_rxd", {24'd0, rxd8}, 32'h3C);
    chk("t1_txr", {31'd0, txr8}, 1);
    // the end-of-word reload finds the buffer empty
    chk("t1_und", und_cnt, 1);

    // mode 3, two back-to-back words, refill between
    txw(0, 16'h00A5);
    exp_rx.push_back(8'h12);
    exp_rx.push_back(8'h34);
    und_cnt = 0;
    fork
      xfer(0, MODE3, 32'h1234, 16, mi);
      begin
        cyc(40);
        txw(0, 16'h0056);
      end
    join
    chk("t2_miso", mi, 32'hA556);
    chk("t2_rxd", {24'd0, rxd8}, 32'h34);
    chk("t2_und", und_cnt, 1);

    // 16-bit slave, modes 1 and 2
    txw(1, 16'hCAFE);
    xfer(1, MODE1, 32'hBEEF, 16, mi);
    chk("t3m1_miso", mi, 32'hCAFE);
    chk("t3m1_rxv", {31'd0, rxv16}, 1);
    chk("t3m1_rxd", {16'd0, rxd16}, 32'hBEEF);
    rx16_ready = 1'b1;
    cyc(1);
    rx16_ready = 1'b0;
    cyc(1);
    chk("t3m1_rxv_clr", {31'd0, rxv16}, 0);
    txw(1, 16'hCAFE);
    xfer(1, MODE2, 32'hBEEF, 16, mi);
    chk("t3m2_miso", mi, 32'hCAFE);
    chk("t3m2_rxv", {31'd0, rxv16}, 1);
    chk("t3m2_rxd", {16'd0, rxd16}, 32'hBEEF);
    chk("t3_idle", {28'd0, oe16, busy16, ovr16, und16}, 0);
    rx16_ready = 1'b1;
    cyc(2);
    rx16_ready = 1'b0;

    // overrun: consumer stalls across two words
    rx_ready = 1'b0;
    txw(0, 16'h0011);
    exp_rx.push_back(8'h5A);
    ovr_cnt = 0;
    und_cnt = 0;
    xfer(0, MODE0, 32'h5AC3, 16, mi);
    chk("t4_miso", mi, 32'h1100);
    chk("t4_ovr", ovr_cnt, 1);
    chk("t4_und", und_cnt, 2);
    chk("t4_rxd", {24'd0, rxd8}, 32'h5A);
    chk("t4_rxv", {31'd0, rxv8}, 1);
    rx_ready = 1'b1;
    cyc(2);
    chk("t4_rxv_clr", {31'd0, rxv8}, 0);

    // underrun: empty TX buffer at SS fall
    exp_rx.push_back(8'h0F);
    und_cnt = 0;
    xfer(0, MODE1, 32'h0F, 8, mi);
    chk("t5_miso", mi, 32'h00);
    chk("t5_und", und_cnt, 2);
    chk("t5_rxd", {24'd0, rxd8}, 32'h0F);

    // abort after 5 bits, then a clean transfer
    txw(0, 16'h0077);
    xfer(0, MODE0, 32'h0B, 5, mi);
    chk("t6_miso", mi, 32'h0E);
    chk("t6_rxv", {31'd0, rxv8}, 0);
    chk("t6_oe", {31'd0, oe8}, 0);
    txw(0, 16'h0099);
    exp_rx.push_back(8'h81);
    xfer(0, MODE0, 32'h81, 8, mi);
    chk("t6_next_miso", mi, 32'h99);
    chk("t6_next_rxd", {24'd0, rxd8}, 32'h81);

    // reset in the middle of a word
    txw(0, 16'h003E);
    fork
      xfer(0, MODE0, 32'h5A, 8, junk);
    join_none
    cyc(30);
    txw(0, 16'h0044);
    chk("t7_txfull", {31'd0, txr8}, 0);
    cyc(10);
    rst_n = 1'b0;
    cyc(2);
    check_reset("rst1");
    wait fork;
    rst_n = 1'b1;
    cyc(4);
    txw(0, 16'h00C3);
    exp_rx.push_back(8'h3C);
    xfer(0, MODE0, 32'h3C, 8, mi);
    chk("t7_next_miso", mi, 32'hC3);
    chk("t7_next_rxd", {24'd0, rxd8}, 32'h3C);

`ifdef SPI_SLAVE_LSB_FIRST_EN
    // LSB first: TX 0x01, master sends 0x80 bit 0 first
    lsb_first = 1'b1;
    txw(0, 16'h0001);
    exp_rx.push_back(8'h80);
    xfer(0, MODE0, 32'h01, 8, mi);
    chk("t8_first_bit", {31'd0, mi[7]}, 1);
    chk("t8_miso", mi, 32'h80);
    chk("t8_rxd", {24'd0, rxd8}, 32'h80);
    lsb_first = 1'b0;
`endif

    cyc(10);
    chk("rx_drain", exp_rx.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave_sync.md
# spi_slave_sync

Parametrised, fully synchronous successor to the current SPI slave: samples SCK/SS/MOSI in the PCLK domain, supports all four SPI modes, WIDTH-bit words, back-to-back words within one SS assertion, and valid/ready buffers on both the TX and RX sides. It sits between an external SPI master and the on-chip register/data path. No logic is clocked by SCK.

## Interface
- WIDTH, 8: bits per word (≥2).
- SYNC_STAGES, 2: synchronizer depth on SCK, SS and MOSI (≥2).
- PCLK  in  1  system clock; all logic on posedge.
- PRESETn  in  1  reset, synchronous, active-low.
- SCK  in  1  SPI clock from master (asynchronous to PCLK).
- SS  in  1  slave select, active-low.
- MOSI  in  1  master-out data.
- MISO  out  1  slave-out data.
- MISO_OE  out  1  output enable for the pad; high only while the synchronized SS is low.
- MODE  in  2  {CPOL, CPHA}; sampled at SS assertion and held for the whole assertion.
- TX_DATA  in  WIDTH  next word to transmit.
- TX_VALID  in  1  TX_DATA valid.
- TX_READY  out  1  TX holding buffer empty.
- RX_DATA  out  WIDTH  last received word.
- RX_VALID  out  1  RX_DATA pending.
- RX_READY  in  1  consumer accepts RX_DATA.
- BUSY  out  1  synchronized SS is low.
- OVERRUN  out  1  one-cycle pulse: a received word was dropped.
- UNDERRUN  out  1  one-cycle pulse: a word started with the TX buffer empty.

## Operation
- Sync: SCK, SS, MOSI each pass through SYNC_STAGES flops. Edges are detected on the synchronized SCK against a one-cycle-delayed copy.
- Edges: leading edge = SCK leaving its CPOL idle level; sample edge = leading if CPHA=0, trailing if CPHA=1; shift edge = the other one.
- FSM IDLE→ACTIVE on synchronized SS falling:
  - latch MODE; clear bit counter;
  - load shift register from the TX buffer, or load all-zeros and pulse UNDERRUN if the buffer is empty;
  - with CPHA=0, MISO presents the first bit on the next cycle.
- ACTIVE: on each sample edge, capture MOSI into the sample bit and increment the counter. On each shift edge, shift the register by one (MSB first) and insert the sample bit; MISO always shows the current MSB. The first shift edge in CPHA=1 updates MISO only.
- Word complete on the WIDTH-th sample edge:
  - assembled word goes to RX_DATA with RX_VALID=1, unless RX_VALID=1 and RX_READY=0 that same cycle; then keep the old RX_DATA and pulse OVERRUN;
  - counter wraps to 0; shift register reloads from the TX buffer (UNDERRUN rule as above), so words run back-to-back.
- ACTIVE→IDLE on synchronized SS rising: partial word discarded, no RX_VALID, counter cleared, MISO_OE and BUSY low the same cycle.
- TX buffer: one entry; TX_READY = empty; a TX_VALID&&TX_READY cycle writes it. A load and a consume in the same cycle are allowed.
- RX: RX_VALID&&RX_READY clears RX_VALID. A new word arriving in that same cycle sets RX_VALID again with the new data; no OVERRUN.

## Timing
- Reset (PRESETn=0 at a PCLK edge): MISO=0, MISO_OE=0, RX_DATA=0, RX_VALID=0, TX_READY=1, BUSY=0, OVERRUN=0, UNDERRUN=0, FSM=IDLE, sync flops=idle (SS=1, SCK=0). Reset mid-transfer aborts without side effects.
- Pin-to-detect latency: SYNC_STAGES+1 PCLK cycles. MISO changes SYNC_STAGES+2 cycles after the pin-level shift edge.
- Constraint: SCK high and low phases each ≥ SYNC_STAGES+2 PCLK cycles. SS to first SCK edge ≥ SYNC_STAGES+3 cycles.
- RX_VALID rises the cycle after the final sample edge is detected. OVERRUN and UNDERRUN are single-cycle pulses.

## Configuration
- SPI_SLAVE_LSB_FIRST_EN defined: adds input LSB_FIRST (1 bit), latched at SS assertion. When it is 1, shift direction reverses for both TX and RX, and MISO shows bit 0.
- Macro undefined: the port is absent and transfers are always MSB first.

## Structure
- Package spi_slave_pkg holds:
  - localparams MODE0..MODE3 = 2'b00..2'b11;
  - FSM state enum {IDLE, ACTIVE};
  - default SYNC_STAGES.
- One sub-module, spi_sync: a SYNC_STAGES-deep single-bit synchronizer with reset value as a parameter, instantiated three times.

## Test plan
- Mode 0, WIDTH=8, TX_DATA=0xA5 preloaded, master sends 0x3C → MISO bits 1,0,1,0,0,1,0,1; RX_DATA=0x3C with RX_VALID=1; TX_READY=1.
- Mode 3, two back-to-back words 0x12, 0x34 in one SS, TX buffer refilled with 0x56 between words → RX gives 0x12 then 0x34; MISO gives 0xA5 then 0x56.
- Modes 1 and 2 with WIDTH=16, master 0xBEEF, TX 0xCAFE → RX_DATA=0xBEEF, MISO 0xCAFE.
- RX_READY held 0 across two words → first word retained, OVERRUN pulses once; empty TX buffer at SS fall → UNDERRUN pulse, MISO all zeros.
- SS deasserted after 5 bits → no RX_VALID, MISO_OE=0; the next full transfer is correct. PRESETn low mid-word → all outputs return to reset values.
- With SPI_SLAVE_LSB_FIRST_EN defined and LSB_FIRST=1, TX 0x01 / master 0x80 (LSB first) → MISO first bit 1; RX_DATA=0x80.
